// File: rtl/dual_core_mem_arbiter_if.sv
// Bus bundle between the core cluster, the arbiter and the shared data-memory port.
// The slave modport is the arbiter's view; master is the cores-plus-memory environment.
interface dual_core_mem_arbiter_if #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32
);
    logic [NUM_CORES-1:0]    core_req_i;
    logic [NUM_CORES-1:0]    core_we_i;
    logic [NUM_CORES*AW-1:0] core_addr_i;
    logic [NUM_CORES*DW-1:0] core_wdata_i;
    logic [NUM_CORES-1:0]    core_ack_o;
    logic [DW-1:0]           core_rdata_o;
    logic [NUM_CORES-1:0]    core_err_o;
    logic [NUM_CORES-1:0]    core_hold_o;
    logic [NUM_CORES-1:0]    core_bus_spare_o;
    logic                    mem_req_o;
    logic                    mem_we_o;
    logic [AW-1:0]           mem_addr_o;
    logic [DW-1:0]           mem_wdata_o;
    logic                    mem_ack_i;
    logic [DW-1:0]           mem_rdata_i;

    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i, mem_ack_i, mem_rdata_i,
        output core_ack_o, core_rdata_o, core_err_o, core_hold_o, core_bus_spare_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output core_req_i, core_we_i, core_addr_i, core_wdata_i, mem_ack_i, mem_rdata_i,
        input  core_ack_o, core_rdata_o, core_err_o, core_hold_o, core_bus_spare_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dual_core_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the cluster cores,
// one transaction at a time, with a saturating ack timeout that returns an error.
module dual_core_mem_arbiter #(
    parameter int unsigned NUM_CORES   = 2,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    dual_core_mem_arbiter_if.slave bus
);

    localparam int unsigned   IW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned   CW       = 8;
    localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT_CYC);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_CORES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         owner, owner_nxt;
    logic [IW-1:0]         last_grant, last_grant_nxt;
    logic [IW-1:0]         winner;
    logic                  any_req;
    logic [CW-1:0]         cnt, cnt_nxt, cnt_inc;
    logic                  timeout;
    logic [NUM_CORES-1:0]  grant;
    logic                  mem_req_nxt, mem_we_nxt;
    logic [AW-1:0]         mem_addr_nxt;
    logic [DW-1:0]         mem_wdata_nxt;
    logic [NUM_CORES-1:0]  ack_nxt, err_nxt;
    logic [DW-1:0]         rdata_nxt;

    // First requester scanning upward from the core after last_grant
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int unsigned k = 1; k <= NUM_CORES; k++) begin
            if (!any_req && bus.core_req_i[IW'((32'(last_grant) + k) % NUM_CORES)]) begin
                winner  = IW'((32'(last_grant) + k) % NUM_CORES);
                any_req = 1'b1;
            end
        end
    end

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);
    assign timeout = (state == BUSY) && !bus.mem_ack_i && (cnt_inc >= TO_LIM);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUSY;
            BUSY:    if (bus.mem_ack_i || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered datapath and core-facing pulses
    always_comb begin
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        mem_req_nxt    = bus.mem_req_o;
        mem_we_nxt     = bus.mem_we_o;
        mem_addr_nxt   = bus.mem_addr_o;
        mem_wdata_nxt  = bus.mem_wdata_o;
        rdata_nxt      = bus.core_rdata_o;
        ack_nxt        = '0;
        err_nxt        = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_nxt      = winner;
                    last_grant_nxt = winner;
                    mem_req_nxt    = 1'b1;
                    mem_we_nxt     = bus.core_we_i[winner];
                    mem_addr_nxt   = bus.core_addr_i[32'(winner)*AW +: AW];
                    mem_wdata_nxt  = bus.core_wdata_i[32'(winner)*DW +: DW];
                end
            end
            BUSY: begin
                if (bus.mem_ack_i) begin
                    mem_req_nxt    = 1'b0;
                    ack_nxt[owner] = 1'b1;
                    if (!bus.mem_we_o) rdata_nxt = bus.mem_rdata_i;
                end else if (timeout) begin
                    mem_req_nxt    = 1'b0;
                    ack_nxt[owner] = 1'b1;
                    err_nxt[owner] = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            RESP:    cnt_nxt = '0;
            default: cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner            <= '0;
            last_grant       <= LAST_RST;
            cnt              <= '0;
            bus.mem_req_o    <= 1'b0;
            bus.mem_we_o     <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.mem_wdata_o  <= '0;
            bus.core_ack_o   <= '0;
            bus.core_err_o   <= '0;
            bus.core_rdata_o <= '0;
        end else begin
            owner            <= owner_nxt;
            last_grant       <= last_grant_nxt;
            cnt              <= cnt_nxt;
            bus.mem_req_o    <= mem_req_nxt;
            bus.mem_we_o     <= mem_we_nxt;
            bus.mem_addr_o   <= mem_addr_nxt;
            bus.mem_wdata_o  <= mem_wdata_nxt;
            bus.core_ack_o   <= ack_nxt;
            bus.core_err_o   <= err_nxt;
            bus.core_rdata_o <= rdata_nxt;
        end
    end

    // In IDLE the would-be winner is not held, so only losers stall that cycle
    always_comb begin
        grant = '0;
        if (state != IDLE)  grant[owner]  = 1'b1;
        else if (any_req)   grant[winner] = 1'b1;
    end

    assign bus.core_hold_o      = bus.core_req_i & ~grant;
    assign bus.core_bus_spare_o = {NUM_CORES{state == IDLE}} & ~bus.core_req_i;

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Directed scoreboard bench for dual_core_mem_arbiter: core and memory models,
// expected memory accesses and core responses queued in predicted order.
module tb_dual_core_mem_arbiter;

    logic clk;
    logic rstn;

    dual_core_mem_arbiter_if #(.NUM_CORES(2), .AW(32), .DW(32)) bus ();

    dual_core_mem_arbiter #(
        .NUM_CORES(2), .AW(32), .DW(32), .TIMEOUT_CYC(8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [1:0]  core;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    req_t        cq0[$];
    req_t        cq1[$];
    exp_t        exp_mem_q[$];
    exp_t        exp_rsp_q[$];
    int          blen_q[$];
    exp_t        mem_cur;
    int          busy_cnt;
    int          mem_delay;
    logic [31:0] hang_addr;
    logic [31:0] last_rdata;
    int          compared;
    int          mismatched;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic drive_cores();
        if (cq0.size() != 0) begin
            bus.core_req_i[0]      = 1'b1;
            bus.core_we_i[0]       = cq0[0].we;
            bus.core_addr_i[31:0]  = cq0[0].addr;
            bus.core_wdata_i[31:0] = cq0[0].wdata;
        end else bus.core_req_i[0] = 1'b0;
        if (cq1.size() != 0) begin
            bus.core_req_i[1]       = 1'b1;
            bus.core_we_i[1]        = cq1[0].we;
            bus.core_addr_i[63:32]  = cq1[0].addr;
            bus.core_wdata_i[63:32] = cq1[0].wdata;
        end else bus.core_req_i[1] = 1'b0;
    endtask

    task automatic issue(input int core, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata;
        if (core == 0) cq0.push_back(r); else cq1.push_back(r);
        drive_cores();
    endtask

    // Push one transaction in predicted completion order
    task automatic sb_push(input int core, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic err);
        exp_t e;
        if (!we && !err) last_rdata = memword(addr);
        e.core = 2'(core); e.we = we; e.addr = addr; e.wdata = wdata;
        e.rdata = last_rdata; e.err = err;
        exp_mem_q.push_back(e);
        exp_rsp_q.push_back(e);
    endtask

    // One clock: check responses and memory accesses at the falling edge, then drive
    task automatic tick();
        exp_t e;
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        if (bus.core_ack_o != 2'b00 || bus.core_err_o != 2'b00) begin
            if (exp_rsp_q.size() == 0)
                check("unexp_ack", 64'({bus.core_err_o, bus.core_ack_o}), 64'd0);
            else begin
                e = exp_rsp_q.pop_front();
                check("ack_vec", 64'(bus.core_ack_o), 64'(2'b01 << e.core));
                check("err_vec", 64'(bus.core_err_o), e.err ? 64'(2'b01 << e.core) : 64'd0);
                check("rdata", 64'(bus.core_rdata_o), 64'(e.rdata));
            end
            if (bus.core_ack_o[0] && cq0.size() != 0) void'(cq0.pop_front());
            if (bus.core_ack_o[1] && cq1.size() != 0) void'(cq1.pop_front());
        end
        drive_cores();
        if (bus.mem_req_o) begin
            if (busy_cnt == 0) begin
                if (exp_mem_q.size() == 0) check("unexp_mem", 64'(bus.mem_req_o), 64'd0);
                else begin
                    mem_cur = exp_mem_q.pop_front();
                    check("mem_we", 64'(bus.mem_we_o), 64'(mem_cur.we));
                    check("mem_addr", 64'(bus.mem_addr_o), 64'(mem_cur.addr));
                    check("mem_wdata", 64'(bus.mem_wdata_o), 64'(mem_cur.wdata));
                end
            end else begin
                check("mem_addr_stable", 64'(bus.mem_addr_o), 64'(mem_cur.addr));
                check("mem_wdata_stable", 64'(bus.mem_wdata_o), 64'(mem_cur.wdata));
            end
            if (busy_cnt == mem_delay && bus.mem_addr_o != hang_addr) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = bus.mem_we_o ? $urandom() : memword(bus.mem_addr_o);
            end
            busy_cnt++;
        end else begin
            if (busy_cnt != 0) blen_q.push_back(busy_cnt);
            busy_cnt = 0;
        end
    endtask

    task automatic wait_done(input int budget);
        int  n = 0;
        logic done;
        while ((exp_rsp_q.size() != 0 || cq0.size() != 0 || cq1.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        done = (exp_rsp_q.size() == 0 && cq0.size() == 0 && cq1.size() == 0);
        check("done_in_budget", 64'(done), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},   64'(bus.mem_req_o), 64'd0);
        check({tag, "_mem_we"},    64'(bus.mem_we_o), 64'd0);
        check({tag, "_mem_addr"},  64'(bus.mem_addr_o), 64'd0);
        check({tag, "_mem_wdata"}, 64'(bus.mem_wdata_o), 64'd0);
        check({tag, "_ack"},       64'(bus.core_ack_o), 64'd0);
        check({tag, "_err"},       64'(bus.core_err_o), 64'd0);
        check({tag, "_rdata"},     64'(bus.core_rdata_o), 64'd0);
        check({tag, "_hold"},      64'(bus.core_hold_o), 64'd0);
        check({tag, "_spare"},     64'(bus.core_bus_spare_o), 64'd3);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cq0.delete(); cq1.delete(); exp_mem_q.delete(); exp_rsp_q.delete(); blen_q.delete();
        drive_cores();
        bus.mem_ack_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        busy_cnt = 0; mem_delay = 0; hang_addr = 32'hFFFF_FFFF; last_rdata = '0;
    endtask

    initial begin
        compared = 0; mismatched = 0;
        busy_cnt = 0; mem_delay = 0; hang_addr = 32'hFFFF_FFFF; last_rdata = '0;
        rstn = 1'b0;
        bus.core_req_i = '0; bus.core_we_i = '0; bus.core_addr_i = '0; bus.core_wdata_i = '0;
        bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
        @(negedge clk);
        check_reset_outputs("rst");
        @(negedge clk);
        rstn = 1'b1;

        // Single read with same-cycle memory ack
        issue(0, 1'b0, 32'h10, 32'h0);
        sb_push(0, 1'b0, 32'h10, 32'h0, 1'b0);
        #1 check("t1_hold_idle", 64'(bus.core_hold_o), 64'd0);
        check("t1_spare_idle", 64'(bus.core_bus_spare_o), 64'd2);
        tick();
        #1 check("t1_mem_req", 64'(bus.mem_req_o), 64'd1);
        check("t1_hold_busy", 64'(bus.core_hold_o), 64'd0);
        tick();
        #1 check("t1_ack_latency", 64'(exp_rsp_q.size()), 64'd0);
        check("t1_mem_req_drop", 64'(bus.mem_req_o), 64'd0);
        check("t1_hold_resp", 64'(bus.core_hold_o), 64'd0);
        tick();
        #1 check("t1_ack_single", 64'(bus.core_ack_o), 64'd0);
        check("t1_spare_after", 64'(bus.core_bus_spare_o), 64'd3);
        check("t1_busy_len", 64'(blen_q.size() > 0 ? blen_q[0] : 0), 64'd1);

        // Stray memory ack while idle must be ignored
        bus.mem_ack_i = 1'b1;
        bus.mem_rdata_i = 32'h1234_5678;
        tick();
        tick();
        #1 check("stray_mem_req", 64'(bus.mem_req_o), 64'd0);
        check("stray_rdata", 64'(bus.core_rdata_o), 64'hDEAD_BEEF);
        check("stray_spare", 64'(bus.core_bus_spare_o), 64'd3);

        // Simultaneous write (core0) and read (core1) right after reset
        do_reset();
        issue(0, 1'b1, 32'h20, 32'h1111_1111);
        issue(1, 1'b0, 32'h24, 32'h0);
        sb_push(0, 1'b1, 32'h20, 32'h1111_1111, 1'b0);
        sb_push(1, 1'b0, 32'h24, 32'h0, 1'b0);
        #1 check("t2_hold_idle", 64'(bus.core_hold_o), 64'd2);
        tick();
        #1 check("t2_hold_busy0", 64'(bus.core_hold_o), 64'd2);
        tick();
        #1 check("t2_hold_resp0", 64'(bus.core_hold_o), 64'd2);
        tick();
        #1 check("t2_hold_idle1", 64'(bus.core_hold_o), 64'd0);
        check("t2_spare_idle1", 64'(bus.core_bus_spare_o), 64'd1);
        tick();
        #1 check("t2_hold_busy1", 64'(bus.core_hold_o), 64'd0);
        wait_done(20);
        tick();

        // Round-robin with both cores requesting continuously
        do_reset();
        issue(0, 1'b0, 32'h100, 32'h0);
        issue(0, 1'b1, 32'h104, 32'hAAAA_0001);
        issue(0, 1'b0, 32'h108, 32'h0);
        issue(1, 1'b1, 32'h200, 32'hBBBB_0002);
        issue(1, 1'b0, 32'h204, 32'h0);
        issue(1, 1'b1, 32'h208, 32'hCCCC_0003);
        sb_push(0, 1'b0, 32'h100, 32'h0, 1'b0);
        sb_push(1, 1'b1, 32'h200, 32'hBBBB_0002, 1'b0);
        sb_push(0, 1'b1, 32'h104, 32'hAAAA_0001, 1'b0);
        sb_push(1, 1'b0, 32'h204, 32'h0, 1'b0);
        sb_push(0, 1'b0, 32'h108, 32'h0, 1'b0);
        sb_push(1, 1'b1, 32'h208, 32'hCCCC_0003, 1'b0);
        wait_done(60);
        tick();

        // Slow memory: ack on the sixth BUSY cycle
        blen_q.delete();
        mem_delay = 5;
        issue(1, 1'b1, 32'h80, 32'hCAFE_F00D);
        sb_push(1, 1'b1, 32'h80, 32'hCAFE_F00D, 1'b0);
        wait_done(30);
        tick();
        check("t4_busy_len", 64'(blen_q.size() > 0 ? blen_q[0] : 0), 64'd6);
        mem_delay = 0;

        // Timeout on core0, then core1 is served normally
        do_reset();
        hang_addr = 32'h90;
        issue(0, 1'b0, 32'h90, 32'h0);
        issue(1, 1'b0, 32'h94, 32'h0);
        sb_push(0, 1'b0, 32'h90, 32'h0, 1'b1);
        sb_push(1, 1'b0, 32'h94, 32'h0, 1'b0);
        wait_done(40);
        tick();
        check("t5_busy_len_to", 64'(blen_q.size() > 0 ? blen_q[0] : 0), 64'd8);
        check("t5_busy_len_next", 64'(blen_q.size() > 1 ? blen_q[1] : 0), 64'd1);

        // Asynchronous reset while core1 read is outstanding
        blen_q.delete();
        hang_addr = 32'h40;
        issue(1, 1'b0, 32'h40, 32'h0);
        begin
            exp_t e;
            e.core = 2'd1; e.we = 1'b0; e.addr = 32'h40; e.wdata = '0; e.rdata = '0; e.err = 1'b0;
            exp_mem_q.push_back(e);
        end
        tick();
        tick();
        tick();
        #1 check("t6_busy_before", 64'(bus.mem_req_o), 64'd1);
        rstn = 1'b0;
        cq1.delete();
        drive_cores();
        #1 check_reset_outputs("rst_mid");
        tick();
        tick();
        #1 check("t6_no_ack", 64'(bus.core_ack_o), 64'd0);
        rstn = 1'b1;
        hang_addr = 32'hFFFF_FFFF;
        last_rdata = '0;
        issue(1, 1'b0, 32'h44, 32'h0);
        issue(0, 1'b0, 32'h48, 32'h0);
        sb_push(0, 1'b0, 32'h48, 32'h0, 1'b0);
        sb_push(1, 1'b0, 32'h44, 32'h0, 1'b0);
        #1 check("t6_hold_tie", 64'(bus.core_hold_o), 64'd2);
        wait_done(20);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
